// File: rtl/fifo_syn_param.sv
// ---------------------------------------------------------------------------
// fifo_syn_param
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full / almost-empty thresholds and sticky overflow / underflow flags.
//
// Compile-time option:
//   FIFO_SYN_FWFT_EN  defined   -> first-word-fall-through read port
//                     undefined -> registered read data, one-cycle latency
//
// Parameters:
//   DATA_WIDTH     bits per entry
//   ADDR_WIDTH     log2 of depth (DEPTH = 2**ADDR_WIDTH)
//   AFULL_THRESH   almost_full  when count >= AFULL_THRESH  (1..DEPTH)
//   AEMPTY_THRESH  almost_empty when count <= AEMPTY_THRESH (0..DEPTH-1)
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   w_en, w_data  write request and data
//   r_en          read (pop) request
//   err_clr       synchronous clear of overflow / underflow
//   r_data        read data
//   empty, full, almost_empty, almost_full, count   registered status
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
// ---------------------------------------------------------------------------
module fifo_syn_param #(
  parameter int DATA_WIDTH    = 384,
  parameter int ADDR_WIDTH    = 3,
  parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

  // A zero almost-full threshold would make almost_full true while empty;
  // the reset value follows the same compare so the flag is never stale.
  localparam logic AFULL_RST = (AFULL_C == '0);

  // Storage is not reset; only pointers and status are.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic                aempty_q, aempty_d;
  logic                afull_q, afull_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  logic                  w_acc;
  logic                  r_acc;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

  // Acceptance uses the registered flags from before the edge: a full FIFO
  // never takes a write in the same cycle as a read frees a slot, and an
  // empty FIFO never forwards a same-cycle write to the read side.
  assign w_acc = w_en & ~full_q;
  assign r_acc = r_en & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (w_acc) begin
      wr_ptr_d = wr_ptr_q + CNT_ONE;
    end
    if (r_acc) begin
      rd_ptr_d = rd_ptr_q + CNT_ONE;
    end

    unique case ({w_acc, r_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Status flags are registered from count_d so they move on the same edge
  // as count itself.
  always_comb begin
    empty_d  = (count_d == '0);
    full_d   = (count_d == DEPTH_C);
    aempty_d = (count_d <= AEMPTY_C);
    afull_d  = (count_d >= AFULL_C);
  end

  // Sticky errors: a new event in the same cycle as err_clr keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (w_en & full_q) begin
      ovf_d = 1'b1;
    end
    if (r_en & empty_q) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= AFULL_RST;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      mem_q[wr_addr] <= w_data;
    end
  end

`ifdef FIFO_SYN_FWFT_EN
  // Head entry is presented combinationally; forced to zero while empty so
  // stale array contents never leak out.
  assign r_data = empty_q ? '0 : mem_q[rd_addr];
`else
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

  always_comb begin
    r_data_d = r_data_q;
    if (r_acc) begin
      r_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_q <= '0;
    end else begin
      r_data_q <= r_data_d;
    end
  end

  assign r_data = r_data_q;
`endif

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = aempty_q;
  assign almost_full  = afull_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
